// File: rtl/bsram_initiator_pkg.sv
// Shared encodings for the BSRAM initiator: access sizes, sequencer states
// and the byte-lane mask used by the sub-word merge path.
package bsram_initiator_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_MERGE_WR = 2'd2;
    localparam logic [1:0] ST_RESP     = 2'd3;

    // One bit per byte lane touched by an access of the given size and offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001 << offset;
            SZ_HALF: mask = 4'b0011 << offset;
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/bsram_initiator_subword_lane.sv
// Combinational byte/halfword lane logic: extract-and-extend for loads,
// read-modify-write merge for stores. Defined for a 32-bit word only.
module bsram_initiator_subword_lane
    import bsram_initiator_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            size,
    input  logic                  is_unsigned,
    input  logic [1:0]            offset,
    input  logic [DATA_WIDTH-1:0] word_in,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] merged
);

    logic [4:0]            shamt_s;
    logic [DATA_WIDTH-1:0] shifted_s;
    logic [DATA_WIDTH-1:0] insert_s;
    logic [DATA_WIDTH-1:0] bit_mask_s;
    logic [3:0]            lanes_s;

    // Lane alignment, load extension and store merge
    always_comb begin
        shamt_s    = {offset, 3'b000};
        shifted_s  = word_in >> shamt_s;
        insert_s   = store_data << shamt_s;
        lanes_s    = lane_mask(size, offset);
        bit_mask_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < 4; i++) begin
            bit_mask_s[i*8 +: 8] = {8{lanes_s[i]}};
        end
        merged = (word_in & ~bit_mask_s) | (insert_s & bit_mask_s);
        case (size)
            SZ_BYTE: load_data = {{(DATA_WIDTH-8){~is_unsigned & shifted_s[7]}}, shifted_s[7:0]};
            SZ_HALF: load_data = {{(DATA_WIDTH-16){~is_unsigned & shifted_s[15]}}, shifted_s[15:0]};
            default: load_data = word_in;
        endcase
    end

endmodule

// File: rtl/bsram_initiator.sv
// Core-side BSRAM initiator: turns byte-addressed load/store requests into
// word accesses, with read-modify-write for sub-word stores.
module bsram_initiator
    import bsram_initiator_pkg::*;
#(
    parameter int CORE       = 0,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_address,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_error,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  readEnable,
    output logic [ADDR_WIDTH-1:0] readAddress,
    input  logic [DATA_WIDTH-1:0] readData,
    output logic                  writeEnable,
    output logic [ADDR_WIDTH-1:0] writeAddress,
    output logic [DATA_WIDTH-1:0] writeData,
    input  logic                  report
);

    localparam int BA_W = ADDR_WIDTH + 2;

    logic [1:0]            state_r;
    logic                  write_r;
    logic [1:0]            size_r;
    logic                  unsigned_r;
    logic [BA_W-1:0]       addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] merged_r;
    logic                  req_ready_r;
    logic                  resp_valid_r;
    logic                  resp_error_r;
    logic [DATA_WIDTH-1:0] resp_data_r;
    logic [31:0]           cycle_r;

    logic                  req_err_s;
    logic                  sub_word_s;
    logic [ADDR_WIDTH-1:0] word_addr_s;
    logic [DATA_WIDTH-1:0] load_data_s;
    logic [DATA_WIDTH-1:0] merged_s;
    logic                  read_en_s;
    logic                  write_en_s;
    logic [ADDR_WIDTH-1:0] read_addr_s;
    logic [ADDR_WIDTH-1:0] write_addr_s;
    logic [DATA_WIDTH-1:0] write_data_s;

    assign sub_word_s  = (size_r != SZ_WORD);
    assign word_addr_s = addr_r[BA_W-1:2];

    bsram_initiator_subword_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .size        (size_r),
        .is_unsigned (unsigned_r),
        .offset      (addr_r[1:0]),
        .word_in     (readData),
        .store_data  (wdata_r),
        .load_data   (load_data_s),
        .merged      (merged_s)
    );

    // Misalignment / illegal-size check on the incoming request
    always_comb begin
        case (req_size)
            SZ_BYTE: req_err_s = 1'b0;
            SZ_HALF: req_err_s = req_address[0];
            SZ_WORD: req_err_s = (req_address[1:0] != 2'b00);
            default: req_err_s = 1'b1;
        endcase
    end

    // BSRAM pin drive; forced idle whenever reset is high so an abandoned op never writes
    always_comb begin
        read_en_s    = 1'b0;
        write_en_s   = 1'b0;
        read_addr_s  = {ADDR_WIDTH{1'b0}};
        write_addr_s = {ADDR_WIDTH{1'b0}};
        write_data_s = {DATA_WIDTH{1'b0}};
        if (reset) begin
            read_en_s  = 1'b0;
            write_en_s = 1'b0;
        end else begin
            case (state_r)
                ST_ISSUE: begin
                    if (write_r && !sub_word_s) begin
                        write_en_s   = 1'b1;
                        write_addr_s = word_addr_s;
                        write_data_s = wdata_r;
                    end else begin
                        read_en_s   = 1'b1;
                        read_addr_s = word_addr_s;
                    end
                end
                ST_MERGE_WR: begin
                    write_en_s   = 1'b1;
                    write_addr_s = word_addr_s;
                    write_data_s = merged_r;
                end
                default: begin
                    read_en_s  = 1'b0;
                    write_en_s = 1'b0;
                end
            endcase
        end
    end

    // Sequencer: request capture, operation stepping and registered response
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            write_r      <= 1'b0;
            size_r       <= 2'b00;
            unsigned_r   <= 1'b0;
            addr_r       <= {BA_W{1'b0}};
            wdata_r      <= {DATA_WIDTH{1'b0}};
            merged_r     <= {DATA_WIDTH{1'b0}};
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_error_r <= 1'b0;
            resp_data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    resp_valid_r <= 1'b0;
                    resp_error_r <= 1'b0;
                    resp_data_r  <= {DATA_WIDTH{1'b0}};
                    if (req_valid) begin
                        write_r     <= req_write;
                        size_r      <= req_size;
                        unsigned_r  <= req_unsigned;
                        addr_r      <= req_address;
                        wdata_r     <= req_wdata;
                        req_ready_r <= 1'b0;
                        if (req_err_s) begin
                            state_r      <= ST_RESP;
                            resp_valid_r <= 1'b1;
                            resp_error_r <= 1'b1;
                        end else begin
                            state_r <= ST_ISSUE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (!write_r) begin
                        resp_data_r  <= load_data_s;
                        resp_valid_r <= 1'b1;
                        state_r      <= ST_RESP;
                    end else if (sub_word_s) begin
                        merged_r <= merged_s;
                        state_r  <= ST_MERGE_WR;
                    end else begin
                        resp_valid_r <= 1'b1;
                        state_r      <= ST_RESP;
                    end
                end
                ST_MERGE_WR: begin
                    resp_valid_r <= 1'b1;
                    state_r      <= ST_RESP;
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    resp_error_r <= 1'b0;
                    resp_data_r  <= {DATA_WIDTH{1'b0}};
                    req_ready_r  <= 1'b1;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    // Free-running cycle count for report output
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_r <= 32'd0;
        end else begin
            cycle_r <= cycle_r + 32'd1;
        end
    end

    // Per-cycle state dump on request
    always_ff @(posedge clock) begin
        if (report) begin
            $display("bsram_initiator core=%0d cycle=%0d state=%0d write=%0b size=%0d unsigned=%0b addr=0x%0h wdata=0x%0h rd=%0b raddr=0x%0h wr=%0b waddr=0x%0h wdata_pin=0x%0h",
                     CORE, cycle_r, state_r, write_r, size_r, unsigned_r, addr_r, wdata_r,
                     read_en_s, read_addr_s, write_en_s, write_addr_s, write_data_s);
        end
    end

    assign req_ready    = req_ready_r;
    assign resp_valid   = resp_valid_r;
    assign resp_error   = resp_error_r;
    assign resp_data    = resp_data_r;
    assign readEnable   = read_en_s;
    assign readAddress  = read_addr_s;
    assign writeEnable  = write_en_s;
    assign writeAddress = write_addr_s;
    assign writeData    = write_data_s;

endmodule

// File: tb/tb_bsram_initiator.sv
// Directed bench for bsram_initiator with a behavioural BSRAM model.
module tb_bsram_initiator;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [9:0]  req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_data;
    logic        readEnable;
    logic [7:0]  readAddress;
    logic [31:0] readData;
    logic        writeEnable;
    logic [7:0]  writeAddress;
    logic [31:0] writeData;
    logic        report;

    logic [31:0] mem [0:255];
    int total = 0;
    int bad = 0;
    int rd_count = 0;
    int wr_count = 0;
    int both_count = 0;

    always #5 clock = ~clock;

    bsram_initiator #(.CORE(0), .DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_error(resp_error),
        .resp_data(resp_data), .readEnable(readEnable), .readAddress(readAddress),
        .readData(readData), .writeEnable(writeEnable), .writeAddress(writeAddress),
        .writeData(writeData), .report(report)
    );

    assign readData = mem[readAddress];

    always @(posedge clock) begin
        if (writeEnable) mem[writeAddress] <= writeData;
        if (readEnable) rd_count <= rd_count + 1;
        if (writeEnable) wr_count <= wr_count + 1;
        if (readEnable && writeEnable) both_count <= both_count + 1;
    end

    // Presents one request at the current (IDLE) negedge; returns one negedge later.
    task automatic present(input logic w, input logic [1:0] sz, input logic u,
                           input logic [9:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_address = a; req_wdata = d;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic run_load(input logic [1:0] sz, input logic u, input logic [9:0] a,
                            output logic v, output logic e, output logic [31:0] d);
        present(1'b0, sz, u, a, 32'h0000_0000);
        @(negedge clock);
        v = resp_valid; e = resp_error; d = resp_data;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", resp_valid); end
        total++; if (resp_error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", resp_error); end
        total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", resp_data); end
        total++; if (readEnable !== 1'b0 || writeEnable !== 1'b0) begin bad++; $display("FAIL reset_enables got=%b%b want=00", readEnable, writeEnable); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_load_byte();
        present(1'b0, 2'd0, 1'b0, 10'h041, 32'h0);
        total++; if (readEnable !== 1'b1) begin bad++; $display("FAIL lb_issue_rd got=%b want=1", readEnable); end
        total++; if (readAddress !== 8'h10) begin bad++; $display("FAIL lb_raddr got=%h want=10", readAddress); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL lb_busy got=%b want=0", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL lb_early_valid got=%b want=0", resp_valid); end
        @(negedge clock);
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL lb_valid got=%b want=1", resp_valid); end
        total++; if (resp_error !== 1'b0) begin bad++; $display("FAIL lb_error got=%b want=0", resp_error); end
        total++; if (resp_data !== 32'hFFFF_FFAA) begin bad++; $display("FAIL lb_data got=%h want=ffffffaa", resp_data); end
        @(negedge clock);
        total++; if (resp_valid !== 1'b0 || resp_data !== 32'h0) begin bad++; $display("FAIL lb_clear got=%b/%h want=0/0", resp_valid, resp_data); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL lb_ready_back got=%b want=1", req_ready); end
    endtask

    task automatic test_load_half_word();
        logic v; logic e; logic [31:0] d;
        run_load(2'd1, 1'b1, 10'h042, v, e, d);
        total++; if (v !== 1'b1 || d !== 32'h0000_8899) begin bad++; $display("FAIL lhu got=%b/%h want=1/00008899", v, d); end
        run_load(2'd2, 1'b0, 10'h040, v, e, d);
        total++; if (v !== 1'b1 || d !== 32'h8899_AABB) begin bad++; $display("FAIL lw got=%b/%h want=1/8899aabb", v, d); end
    endtask

    task automatic test_store_subword();
        logic v; logic e; logic [31:0] d;
        present(1'b1, 2'd0, 1'b0, 10'h043, 32'hFFFF_FF5C);
        total++; if (readEnable !== 1'b1 || writeEnable !== 1'b0) begin bad++; $display("FAIL sb_issue got=%b%b want=10", readEnable, writeEnable); end
        @(negedge clock);
        total++; if (writeEnable !== 1'b1 || readEnable !== 1'b0) begin bad++; $display("FAIL sb_merge_en got=%b%b want=01", readEnable, writeEnable); end
        total++; if (writeAddress !== 8'h10) begin bad++; $display("FAIL sb_waddr got=%h want=10", writeAddress); end
        total++; if (writeData !== 32'h5C99_AABB) begin bad++; $display("FAIL sb_wdata got=%h want=5c99aabb", writeData); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL sb_early_valid got=%b want=0", resp_valid); end
        @(negedge clock);
        total++; if (resp_valid !== 1'b1 || resp_error !== 1'b0 || resp_data !== 32'h0) begin bad++; $display("FAIL sb_resp got=%b/%b/%h want=1/0/0", resp_valid, resp_error, resp_data); end
        @(negedge clock);
        total++; if (mem[16] !== 32'h5C99_AABB) begin bad++; $display("FAIL sb_mem got=%h want=5c99aabb", mem[16]); end
        run_load(2'd2, 1'b0, 10'h040, v, e, d);
        total++; if (d !== 32'h5C99_AABB) begin bad++; $display("FAIL sb_readback got=%h want=5c99aabb", d); end

        present(1'b1, 2'd1, 1'b0, 10'h040, 32'h1234_F00D);
        @(negedge clock);
        total++; if (writeEnable !== 1'b1 || writeData !== 32'h5C99_F00D) begin bad++; $display("FAIL sh_wdata got=%b/%h want=1/5c99f00d", writeEnable, writeData); end
        @(negedge clock);
        @(negedge clock);
        run_load(2'd1, 1'b0, 10'h040, v, e, d);
        total++; if (d !== 32'hFFFF_F00D) begin bad++; $display("FAIL lh_signed got=%h want=fffff00d", d); end
        run_load(2'd0, 1'b1, 10'h040, v, e, d);
        total++; if (d !== 32'h0000_000D) begin bad++; $display("FAIL lbu got=%h want=0000000d", d); end
        run_load(2'd0, 1'b0, 10'h043, v, e, d);
        total++; if (d !== 32'h0000_005C) begin bad++; $display("FAIL lb_pos got=%h want=0000005c", d); end
        run_load(2'd1, 1'b0, 10'h042, v, e, d);
        total++; if (d !== 32'h0000_5C99) begin bad++; $display("FAIL lh_pos got=%h want=00005c99", d); end
    endtask

    task automatic test_back_to_back();
        int wr0;
        wr0 = wr_count;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_address = 10'h008; req_wdata = 32'hDEAD_BEEF;
        @(negedge clock);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_busy1 got=%b want=0", req_ready); end
        total++; if (writeEnable !== 1'b1 || writeAddress !== 8'h02 || writeData !== 32'hDEAD_BEEF) begin bad++; $display("FAIL b2b_write got=%b/%h/%h want=1/02/deadbeef", writeEnable, writeAddress, writeData); end
        @(negedge clock);
        total++; if (req_ready !== 1'b0 || resp_valid !== 1'b1) begin bad++; $display("FAIL b2b_resp got=%b/%b want=0/1", req_ready, resp_valid); end
        @(negedge clock);
        total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b/%b want=1/0", req_ready, resp_valid); end
        total++; if (wr_count !== wr0 + 1) begin bad++; $display("FAIL b2b_pulses got=%0d want=%0d", wr_count, wr0 + 1); end
        req_write = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        total++; if (readEnable !== 1'b1 || readAddress !== 8'h02) begin bad++; $display("FAIL b2b_accept2 got=%b/%h want=1/02", readEnable, readAddress); end
        @(negedge clock);
        total++; if (resp_valid !== 1'b1 || resp_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL b2b_load got=%b/%h want=1/deadbeef", resp_valid, resp_data); end
        @(negedge clock);
        total++; if (wr_count !== wr0 + 1 || mem[2] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL b2b_mem got=%0d/%h want=%0d/deadbeef", wr_count, mem[2], wr0 + 1); end
    endtask

    task automatic test_misaligned();
        logic        w_v  [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  sz_v [3] = '{2'd1, 2'd2, 2'd3};
        logic [9:0]  a_v  [3] = '{10'h001, 10'h006, 10'h000};
        int rd0;
        int wr0;
        rd0 = rd_count; wr0 = wr_count;
        for (int i = 0; i < 3; i++) begin
            present(w_v[i], sz_v[i], 1'b0, a_v[i], 32'hCAFE_F00D);
            total++; if (resp_valid !== 1'b1 || resp_error !== 1'b1 || resp_data !== 32'h0) begin bad++; $display("FAIL mis%0d_resp got=%b/%b/%h want=1/1/0", i, resp_valid, resp_error, resp_data); end
            total++; if (readEnable !== 1'b0 || writeEnable !== 1'b0) begin bad++; $display("FAIL mis%0d_en got=%b%b want=00", i, readEnable, writeEnable); end
            @(negedge clock);
            total++; if (resp_valid !== 1'b0 || resp_error !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL mis%0d_clear got=%b/%b/%b want=0/0/1", i, resp_valid, resp_error, req_ready); end
        end
        total++; if (rd_count !== rd0 || wr_count !== wr0) begin bad++; $display("FAIL mis_no_access got=%0d/%0d want=%0d/%0d", rd_count, wr_count, rd0, wr0); end
        total++; if (mem[0] !== 32'h0 || mem[1] !== 32'h0) begin bad++; $display("FAIL mis_mem got=%h/%h want=0/0", mem[0], mem[1]); end
    endtask

    task automatic test_reset_in_merge();
        int wr0;
        wr0 = wr_count;
        present(1'b1, 2'd0, 1'b0, 10'h080, 32'h0000_00EE);
        total++; if (readEnable !== 1'b1) begin bad++; $display("FAIL rst_issue got=%b want=1", readEnable); end
        @(negedge clock);
        total++; if (writeEnable !== 1'b1) begin bad++; $display("FAIL rst_in_merge got=%b want=1", writeEnable); end
        reset = 1'b1;
        #1;
        total++; if (writeEnable !== 1'b0 || readEnable !== 1'b0) begin bad++; $display("FAIL rst_gate got=%b%b want=00", readEnable, writeEnable); end
        @(negedge clock);
        reset = 1'b0;
        total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL rst_after got=%b/%b want=1/0", req_ready, resp_valid); end
        @(negedge clock);
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_no_resp got=%b want=0", resp_valid); end
        total++; if (mem[32] !== 32'h1122_3344 || wr_count !== wr0) begin bad++; $display("FAIL rst_mem got=%h/%0d want=11223344/%0d", mem[32], wr_count, wr0); end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_address = 10'h0; req_wdata = 32'h0; report = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[16] = 32'h8899_AABB;
        mem[32] = 32'h1122_3344;
        test_reset();
        test_load_byte();
        test_load_half_word();
        test_store_subword();
        test_back_to_back();
        test_misaligned();
        test_reset_in_merge();
        total++; if (both_count !== 0) begin bad++; $display("FAIL rd_wr_overlap got=%0d want=0", both_count); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
